// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: bus widths, stall encodings,
// FSM state encodings and reset polarity.
package pipe_ctrl_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and pipe_ctrl: stall requests and branch
// resolution in, stall/flush/redirect and performance counters out.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   stallreq_if;
    logic                   stallreq_id;
    logic                   stallreq_ex;
    logic                   stallreq_mem;
    logic                   branch_i;
    logic [InstAddrBus-1:0] branch_target_i;
    logic [5:0]             stall_o;
    logic                   flush_o;
    logic                   redirect_o;
    logic [InstAddrBus-1:0] redirect_pc_o;
    logic [RegBus-1:0]      cycle_cnt_o;
    logic [RegBus-1:0]      stall_cnt_o;
    logic [RegBus-1:0]      flush_cnt_o;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output branch_i, branch_target_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o,
        input  cycle_cnt_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_i, branch_target_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o,
        output cycle_cnt_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running 32-bit event counter, wraps modulo 2^32, clears on synchronous reset.
module perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    output logic [RegBus-1:0] cnt_o
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_o <= ZeroWord;
        end else if (inc_i) begin
            cnt_o <= cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector merge, wrong-path flush and (possibly deferred) PC redirect.
// Optional performance counters are built only with PIPE_CTRL_PERF_EN defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    state_t                 state, state_nxt;
    logic [InstAddrBus-1:0] pend_pc, pend_pc_nxt;
    logic [5:0]             stall_hi;
    logic [5:0]             stall;
    logic                   acc;
    logic                   flush;
    logic                   id_eff;
    logic                   redir;
    logic [InstAddrBus-1:0] redir_pc;

    always_comb begin
        state_nxt   = state;
        pend_pc_nxt = pend_pc;
        stall_hi    = STALL_NONE;
        stall       = STALL_NONE;
        acc         = 1'b0;
        flush       = 1'b0;
        id_eff      = 1'b0;
        redir       = 1'b0;
        redir_pc    = ZeroWord;
        if (rst != RstEnable) begin
            // EX-stop depends only on mem/ex, which breaks the acc -> flush -> id_eff loop
            if (bus.stallreq_mem)     stall_hi = STALL_MEM;
            else if (bus.stallreq_ex) stall_hi = STALL_EX;
            acc    = (state == RUN) && bus.branch_i && (stall_hi[3] == NoStop);
            flush  = acc || (state == PEND);
            id_eff = bus.stallreq_id && !flush;
            if (bus.stallreq_mem)      stall = STALL_MEM;
            else if (bus.stallreq_ex)  stall = STALL_EX;
            else if (id_eff)           stall = STALL_ID;
            else if (bus.stallreq_if)  stall = STALL_IF;
            else                       stall = STALL_NONE;
            case (state)
                RUN: begin
                    if (acc) begin
                        if (stall[0] == NoStop) begin
                            redir    = 1'b1;
                            redir_pc = bus.branch_target_i;
                        end else begin
                            pend_pc_nxt = bus.branch_target_i;
                            state_nxt   = PEND;
                        end
                    end
                end
                PEND: begin
                    if (stall[0] == NoStop) begin
                        redir     = 1'b1;
                        redir_pc  = pend_pc;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state   <= RUN;
            pend_pc <= ZeroWord;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    assign bus.stall_o       = stall;
    assign bus.flush_o       = flush;
    assign bus.redirect_o    = redir;
    assign bus.redirect_pc_o = redir_pc;

`ifdef PIPE_CTRL_PERF_EN
    logic [RegBus-1:0] cycle_cnt, stall_cnt, flush_cnt;

    perf_cnt u_cycle_cnt (.clk(clk), .rst(rst), .inc_i(rst != RstEnable), .cnt_o(cycle_cnt));
    perf_cnt u_stall_cnt (.clk(clk), .rst(rst), .inc_i(stall[0] == Stop),  .cnt_o(stall_cnt));
    perf_cnt u_flush_cnt (.clk(clk), .rst(rst), .inc_i(acc),               .cnt_o(flush_cnt));

    // Outputs read zero while reset is held, before the clearing edge lands
    assign bus.cycle_cnt_o = (rst == RstEnable) ? ZeroWord : cycle_cnt;
    assign bus.stall_cnt_o = (rst == RstEnable) ? ZeroWord : stall_cnt;
    assign bus.flush_cnt_o = (rst == RstEnable) ? ZeroWord : flush_cnt;
`else
    assign bus.cycle_cnt_o = ZeroWord;
    assign bus.stall_cnt_o = ZeroWord;
    assign bus.flush_cnt_o = ZeroWord;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        bit          chk_cnt;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "stall",  {26'd0, bus.stall_o}, {26'd0, e.stall});
            cmp(e.name, "flush",  {31'd0, bus.flush_o}, {31'd0, e.flush});
            cmp(e.name, "redir",  {31'd0, bus.redirect_o}, {31'd0, e.redir});
            cmp(e.name, "rpc",    bus.redirect_pc_o, e.rpc);
            if (e.chk_cnt) begin
                cmp(e.name, "cycle_cnt", bus.cycle_cnt_o, e.cyc);
                cmp(e.name, "stall_cnt", bus.stall_cnt_o, 32'd0);
                cmp(e.name, "flush_cnt", bus.flush_cnt_o, 32'd0);
            end
        end
    end

    // Drive one cycle of inputs just after a posedge, queue its expectation, advance.
    task automatic step(input string nm, input bit r, input bit m, input bit e, input bit i,
                        input bit f, input bit b, input logic [31:0] t,
                        input logic [5:0] es, input bit ef, input bit er, input logic [31:0] ep,
                        input bit cc, input logic [31:0] ecyc);
        exp_t x;
        rst                 = r;
        bus.stallreq_mem    = m;
        bus.stallreq_ex     = e;
        bus.stallreq_id     = i;
        bus.stallreq_if     = f;
        bus.branch_i        = b;
        bus.branch_target_i = t;
        x.name = nm; x.stall = es; x.flush = ef; x.redir = er; x.rpc = ep;
        x.chk_cnt = cc; x.cyc = ecyc;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.stallreq_mem = 1'b0; bus.stallreq_ex = 1'b0; bus.stallreq_id = 1'b0;
        bus.stallreq_if = 1'b0; bus.branch_i = 1'b0; bus.branch_target_i = 32'h0;
        @(posedge clk);
        #1;
        //    name          rst m e i f b target        stall      fl rd rpc        cc cyc
        step("rst_all",      1, 1,1,1,1,1, 32'h0000_0100, 6'b000000, 0, 0, 32'h0,     0, 0);
        step("rst_hold",     1, 0,0,0,0,1, 32'h0000_0100, 6'b000000, 0, 0, 32'h0,     0, 0);
        step("idle0",        0, 0,0,0,0,0, 32'h0,         6'b000000, 0, 0, 32'h0,     1, 0);
        step("id_alone",     0, 0,0,1,0,0, 32'h0,         6'b000111, 0, 0, 32'h0,     0, 0);
        step("id_mem",       0, 1,0,1,0,0, 32'h0,         6'b011111, 0, 0, 32'h0,     0, 0);
        step("br_100",       0, 0,0,0,0,1, 32'h0000_0100, 6'b000000, 1, 1, 32'h100,   0, 0);
        step("after_100",    0, 0,0,0,0,0, 32'h0,         6'b000000, 0, 0, 32'h0,     0, 0);
        step("br_200_if1",   0, 0,0,0,1,1, 32'h0000_0200, 6'b000011, 1, 0, 32'h0,     0, 0);
        step("pend_if2",     0, 0,0,0,1,1, 32'h0000_0300, 6'b000011, 1, 0, 32'h0,     0, 0);
        step("pend_if3",     0, 0,0,1,1,0, 32'h0,         6'b000011, 1, 0, 32'h0,     0, 0);
        step("pend_rdr",     0, 0,0,0,0,0, 32'h0,         6'b000000, 1, 1, 32'h200,   0, 0);
        step("run_again",    0, 0,0,0,0,0, 32'h0,         6'b000000, 0, 0, 32'h0,     0, 0);
        step("br_ex_hold",   0, 0,1,0,0,1, 32'h0000_0400, 6'b001111, 0, 0, 32'h0,     0, 0);
        step("br_ex_drop",   0, 0,0,0,0,1, 32'h0000_0400, 6'b000000, 1, 1, 32'h400,   0, 0);
        step("br_id_mask",   0, 0,0,1,0,1, 32'h0000_0500, 6'b000000, 1, 1, 32'h500,   0, 0);
        step("br_600_if",    0, 0,0,0,1,1, 32'h0000_0600, 6'b000011, 1, 0, 32'h0,     0, 0);
        step("pend_mem",     0, 1,0,0,0,0, 32'h0,         6'b011111, 1, 0, 32'h0,     0, 0);
        step("pend_ex",      0, 0,1,0,0,0, 32'h0,         6'b001111, 1, 0, 32'h0,     0, 0);
        step("pend_rdr600",  0, 0,0,0,0,0, 32'h0,         6'b000000, 1, 1, 32'h600,   0, 0);
        step("br_700_if",    0, 0,0,0,1,1, 32'h0000_0700, 6'b000011, 1, 0, 32'h0,     0, 0);
        step("rst_in_pend",  1, 0,0,0,1,0, 32'h0,         6'b000000, 0, 0, 32'h0,     0, 0);
        step("post_rst",     0, 0,0,0,0,0, 32'h0,         6'b000000, 0, 0, 32'h0,     1, 0);
        for (int k = 1; k < 10; k++)
            step("free_run",  0, 0,0,0,0,0, 32'h0,         6'b000000, 0, 0, 32'h0,     0, 0);
        step("free_run10",   0, 0,0,0,0,0, 32'h0,         6'b000000, 0, 0, 32'h0,     1, PERF ? 32'd10 : 32'd0);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core: merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also turns an EX-resolved taken branch into a wrong-path flush and a PC redirect. The PC redirect is deferred while an instruction fetch is still outstanding. The block sits beside the pipeline registers and drives their `stall` and flush inputs.

## Interface
- Parameters: none; widths come from the shared defines (`RegBus` = 32, `InstAddrBus` = 32).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (`RstEnable` = 1)
- stallreq_if  in  1  fetch transaction outstanding (cannot be aborted)
- stallreq_id  in  1  load-use hazard in ID
- stallreq_ex  in  1  multi-cycle operation in EX
- stallreq_mem  in  1  data memory access busy
- branch_i  in  1  taken branch/jump resolved in EX this cycle
- branch_target_i  in  32  target of branch_i
- stall_o  out  6  stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop
- flush_o  out  1  IF/ID and ID/EX load bubbles (NOP op, write disable) this edge
- redirect_o  out  1  PC register loads redirect_pc_o this edge
- redirect_pc_o  out  32  redirect target
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  32 each  performance counters (see Configuration)

## Operation
- States: RUN, PEND. Registers: state, pend_pc[31:0].
- acc = (state == RUN) && branch_i && stall_o[3] == NoStop.
- flush_o = acc || (state == PEND).
- Effective ID request: id_eff = stallreq_id && !flush_o. The hazard belongs to a wrong-path instruction, so it is masked.
- stall_o priority, highest first:
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - id_eff -> 6'b000111
  - stallreq_if -> 6'b000011
  - otherwise -> 6'b000000
- RUN:
  - If acc and stall_o[0] == 0: redirect_o = 1, redirect_pc_o = branch_target_i, stay in RUN.
  - If acc and stall_o[0] == 1: pend_pc <= branch_target_i, go to PEND, redirect_o = 0.
- PEND:
  - branch_i is ignored; EX holds only bubbles.
  - When stall_o[0] == 0: redirect_o = 1, redirect_pc_o = pend_pc, go to RUN.
  - Otherwise stay in PEND.
- redirect_pc_o = 0 whenever redirect_o = 0.
- branch_i while stall_o[3] == Stop is not accepted. EX holds the branch and re-presents it.

## Timing
- stall_o, flush_o, redirect_o and redirect_pc_o are combinational from the inputs and state. There are zero cycles of latency from a request to the vector.
- The PEND→RUN transition happens on the same edge that the PC loads pend_pc.
- Minimum PEND duration is 1 cycle. There is no maximum; the block waits on stallreq_if, stallreq_mem and stallreq_ex.
- Simultaneous acc and stallreq_mem is impossible: mem forces stall_o[3] = 1, so acc = 0.
- While rst = 1, all outputs are forced to 0 (stall_o = 6'b000000). On the reset edge: state <= RUN, pend_pc <= 0, counters <= 0.
- Reset in PEND discards the pending redirect.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - cycle_cnt_o increments every cycle with rst = 0.
  - stall_cnt_o increments when stall_o[0] = 1.
  - flush_cnt_o increments when acc = 1.
  - All counters wrap modulo 2^32 and clear on reset.
- Undefined: the three counter ports remain present and are tied to 32'h0, and no counter flops are built.

## Structure
- Shared defines file:
  - Stop/NoStop
  - the five stall patterns (STALL_MEM, STALL_EX, STALL_ID, STALL_IF, STALL_NONE)
  - PEND/RUN state encodings
  - ZeroWord
  - RstEnable
- Sub-module `perf_cnt`: 32-bit counter with clk, rst, inc_i and cnt_o. It is instantiated three times, only under `PIPE_CTRL_PERF_EN`.

## Test plan
- stallreq_id = 1 alone -> stall_o = 6'b000111, flush_o = 0. Add stallreq_mem = 1 -> stall_o = 6'b011111.
- branch_i = 1, target 0x0000_0100, no requests -> same cycle: flush_o = 1, redirect_o = 1, redirect_pc_o = 0x100; state stays RUN.
- branch_i = 1 with target 0x200 and stallreq_if = 1 for 3 cycles:
  - flush_o = 1 for 4 cycles and stall_o = 6'b000011 for 3 cycles.
  - redirect_o = 1 with 0x200 in the 4th cycle, then RUN.
- branch_i = 1 with stallreq_ex = 1 -> stall_o = 6'b001111, flush_o = 0, redirect_o = 0. Drop stallreq_ex next cycle -> branch accepted and redirected.
- branch_i = 1 with stallreq_id = 1 -> stall_o = 6'b000000, flush_o = 1, redirect_o = 1.
- Assert rst during PEND, then release with stallreq_if = 0 -> redirect_o = 0; counters read 0. With `PIPE_CTRL_PERF_EN`, 10 free-running cycles -> cycle_cnt_o = 10.
